// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    function automatic owner_t other(input owner_t o);
        return (o == OWN_A) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with its own priority register.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    owner_t prio;
    owner_t winner;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            unique case (1'b1)
                (req == 2'b11): gnt = (prio == OWN_A) ? 2'b01 : 2'b10;
                (req == 2'b01): gnt = 2'b01;
                (req == 2'b10): gnt = 2'b10;
                default:        gnt = 2'b00;
            endcase
        end
    end

    assign winner = gnt[1] ? OWN_B : OWN_A;

    // After a transfer the loser gets first claim on the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= OWN_A;
        end else if (accept) begin
            prio <= other(winner);
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between requesters A and B,
// routing registered read data back to whichever side issued the read.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic [1:0]            gnt;
    logic                  granted;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  pend;
    owner_t                owner;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({b_valid, a_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];
    assign granted = |gnt;
    assign accept  = |(gnt & {b_valid, a_valid});

    assign sel_we    = gnt[1] ? b_we    : a_we;
    assign sel_addr  = gnt[1] ? b_addr  : a_addr;
    assign sel_wdata = gnt[1] ? b_wdata : a_wdata;

    // Idle cycles replay the last address/data so the RAM inputs never glitch
    assign ram_we   = granted & sel_we;
    assign ram_addr = granted ? sel_addr  : addr_q;
    assign ram_din  = granted ? sel_wdata : din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            din_q  <= '0;
            pend   <= 1'b0;
            owner  <= OWN_A;
        end else begin
            addr_q <= ram_addr;
            din_q  <= ram_din;
            pend   <= accept & ~sel_we;
            if (accept) begin
                owner <= gnt[1] ? OWN_B : OWN_A;
            end
        end
    end

    // A read in flight when reset hits is dropped, not returned
    assign a_rvalid = pend & (owner == OWN_A) & ~rst;
    assign b_rvalid = pend & (owner == OWN_B) & ~rst;
    assign a_rdata  = a_rvalid ? ram_dout : '0;
    assign b_rdata  = b_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: arbiter plus single-port RAM against a behavioural model.
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
        .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
        .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Downstream single-port RAM, read-first, registered output
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [16];
    logic          mprio = 1'b0;
    logic          mpend = 1'b0;
    logic          mown  = 1'b0;
    logic [DW-1:0] mdata = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;
    logic [1:0]    m_last_g = 2'b00;

    function automatic logic [1:0] exp_grant(input logic r, input logic av,
                                             input logic bv, input logic p);
        if (r) return 2'b00;
        if (av && bv) return p ? 2'b10 : 2'b01;
        return {bv, av};
    endfunction

    task automatic model_advance();
        logic [1:0]    g;
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        g = exp_grant(rst, a_valid, b_valid, mprio);
        m_last_g = g;
        if (rst) begin
            mprio = 1'b0; mpend = 1'b0; m_addr = '0; m_din = '0;
        end else begin
            mpend = 1'b0;
            if (g != 2'b00) begin
                we = g[0] ? a_we : b_we;
                ad = g[0] ? a_addr : b_addr;
                d  = g[0] ? a_wdata : b_wdata;
                m_addr = ad;
                m_din  = d;
                if (we) ref_mem[ad] = d;
                else begin
                    mpend = 1'b1; mown = g[1]; mdata = ref_mem[ad];
                end
                mprio = g[0];
            end
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] d);
        a_valid = v; a_we = we; a_addr = ad; a_wdata = d;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] d);
        b_valid = v; b_we = we; b_addr = ad; b_wdata = d;
    endtask

    task automatic test_reset();
        set_a(1, 0, 0, 0);
        set_b(1, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if ({a_ready, b_ready} !== 2'b00) begin
                fails++; $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready});
            end
            tests++;
            if ({a_rvalid, b_rvalid, ram_we} !== 3'b000) begin
                fails++; $display("FAIL reset_rvalid_we: got %b want 000", {a_rvalid, b_rvalid, ram_we});
            end
            tests++;
            if ({a_rdata, b_rdata, ram_addr, ram_din} !== '0) begin
                fails++; $display("FAIL reset_zero: got %h %h %h %h want 0", a_rdata, b_rdata, ram_addr, ram_din);
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_ready, b_ready} !== 2'b10) begin
            fails++; $display("FAIL reset_first_grant: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        tick();
        set_a(0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (b_ready !== 1'b1) begin
            fails++; $display("FAIL reset_b_alone: got %b want 1", b_ready);
        end
        tick();
        set_b(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_preload();
        for (int i = 0; i < 16; i++) begin
            set_a(1, 1, AW'(i), DW'(i * 17));
            @(negedge clk);
            tests++;
            if ({a_ready, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, AW'(i), DW'(i * 17)}) begin
                fails++; $display("FAIL preload: got rdy=%b we=%b addr=%h din=%h want 1 1 %h %h",
                                  a_ready, ram_we, ram_addr, ram_din, AW'(i), DW'(i * 17));
            end
            tick();
        end
        set_a(0, 0, 0, 0);
    endtask

    task automatic test_single();
        set_a(1, 1, 3, 8'h5A);
        @(negedge clk);
        tests++;
        if (a_ready !== 1'b1) begin
            fails++; $display("FAIL single_wr_ready: got %b want 1", a_ready);
        end
        tick();
        set_a(1, 0, 3, 0);
        @(negedge clk);
        tests++;
        if (a_ready !== 1'b1 || a_rvalid !== 1'b0) begin
            fails++; $display("FAIL single_rd_ready: got rdy=%b rv=%b want 1 0", a_ready, a_rvalid);
        end
        tick();
        set_a(0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if ({a_rvalid, a_rdata, b_rvalid} !== {1'b1, 8'h5A, 1'b0}) begin
            fails++; $display("FAIL single_rdata: got rv=%b d=%h brv=%b want 1 5a 0", a_rvalid, a_rdata, b_rvalid);
        end
        tick();
        @(negedge clk);
        tests++;
        if (a_rvalid !== 1'b0) begin
            fails++; $display("FAIL single_pulse: got %b want 0", a_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        set_b(1, 1, 4'hF, 8'hFF);
        tick();
        set_b(0, 0, 0, 0);
        set_a(1, 0, 1, 0);
        set_b(1, 0, 2, 0);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
            end
            @(negedge clk);
            if (k < 6) begin
                tests++;
                if ({a_ready, b_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    fails++; $display("FAIL contention_grant[%0d]: got a=%b b=%b", k, a_ready, b_ready);
                end
            end
            if (k > 0) begin
                tests++;
                if ((k % 2 == 1) ? ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, 8'h11})
                                 : ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, 8'h22})) begin
                    fails++; $display("FAIL contention_rdata[%0d]: got rv=%b%b a=%h b=%h", k,
                                      a_rvalid, b_rvalid, a_rdata, b_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_old_data();
        set_a(1, 1, 5, 8'h33);
        tick();
        set_a(1, 0, 5, 0);
        tick();
        set_a(0, 0, 0, 0);
        set_b(1, 1, 5, 8'h77);
        @(negedge clk);
        tests++;
        if ({b_ready, a_rvalid, a_rdata} !== {2'b11, 8'h33}) begin
            fails++; $display("FAIL old_data: got brdy=%b rv=%b d=%h want 1 1 33", b_ready, a_rvalid, a_rdata);
        end
        tick();
        set_b(0, 0, 0, 0);
        set_a(1, 0, 5, 0);
        tick();
        set_a(0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if ({a_rvalid, a_rdata} !== {1'b1, 8'h77}) begin
            fails++; $display("FAIL new_data: got rv=%b d=%h want 1 77", a_rvalid, a_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        set_a(1, 0, 7, 0);
        tick();
        set_a(0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (a_rvalid !== 1'b0) begin
            fails++; $display("FAIL midrd_rvalid_rst: got %b want 0", a_rvalid);
        end
        tick();
        rst = 1'b0;
        set_a(1, 0, 0, 0);
        set_b(1, 0, 0, 0);
        @(negedge clk);
        tests++;
        if ({a_rvalid, a_ready, b_ready} !== 3'b010) begin
            fails++; $display("FAIL midrd_after: got rv=%b a=%b b=%b want 0 1 0", a_rvalid, a_ready, b_ready);
        end
        tick();
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_idle_hold();
        set_a(1, 1, 4'hC, 8'hC3);
        tick();
        set_a(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({ram_we, ram_addr, ram_din} !== {1'b0, 4'hC, 8'hC3}) begin
                fails++; $display("FAIL idle_hold[%0d]: got we=%b addr=%h din=%h want 0 c c3",
                                  i, ram_we, ram_addr, ram_din);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [1:0]    eg;
        logic          erva, ervb, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edin;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(39) == 0);
            if (!a_valid && $urandom_range(2) != 0)
                set_a(1, 1'($urandom), AW'($urandom), DW'($urandom));
            if (!b_valid && $urandom_range(2) != 0)
                set_b(1, 1'($urandom), AW'($urandom), DW'($urandom));
            @(negedge clk);
            eg    = exp_grant(rst, a_valid, b_valid, mprio);
            erva  = mpend && !mown && !rst;
            ervb  = mpend && mown && !rst;
            ewe   = eg[0] ? a_we : (eg[1] ? b_we : 1'b0);
            eaddr = eg[0] ? a_addr : (eg[1] ? b_addr : m_addr);
            edin  = eg[0] ? a_wdata : (eg[1] ? b_wdata : m_din);
            tests++;
            if ({a_ready, b_ready} !== {eg[0], eg[1]}) begin
                fails++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", n, a_ready, b_ready, eg[0], eg[1]);
            end
            tests++;
            if ({a_rvalid, b_rvalid} !== {erva, ervb}) begin
                fails++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", n, a_rvalid, b_rvalid, erva, ervb);
            end
            tests++;
            if (a_rdata !== (erva ? mdata : 8'h00) || b_rdata !== (ervb ? mdata : 8'h00)) begin
                fails++; $display("FAIL rnd_rdata[%0d]: got a=%h b=%h want data %h", n, a_rdata, b_rdata, mdata);
            end
            tests++;
            if ({ram_we, ram_addr, ram_din} !== {ewe, eaddr, edin}) begin
                fails++; $display("FAIL rnd_ram[%0d]: got %b %h %h want %b %h %h", n,
                                  ram_we, ram_addr, ram_din, ewe, eaddr, edin);
            end
            tick();
            if (m_last_g[0]) a_valid = 1'b0;
            if (m_last_g[1]) b_valid = 1'b0;
        end
        rst = 1'b0;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        tick();
        test_reset();
        test_preload();
        test_single();
        test_contention();
        test_old_data();
        test_reset_mid_read();
        test_idle_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin arbiter that sits directly upstream of the team's single-port synchronous RAM (one access per clock, registered read data, 1-cycle read latency) and shares its one port between requesters A and B. Each requester uses a valid/ready request channel. Read data is routed back to whichever requester issued the read.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 4, RAM address width (depth 2**ADDR_WIDTH)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- a_valid  in  1  requester A has a request
- a_ready  out  1  A's request is accepted this cycle
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  A address
- a_wdata  in  DATA_WIDTH  A write data
- a_rvalid  out  1  A read data valid (one-cycle pulse)
- a_rdata  out  DATA_WIDTH  A read data
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata  same as A, for requester B
- ram_we  out  1  to RAM write enable
- ram_addr  out  ADDR_WIDTH  to RAM address
- ram_din  out  DATA_WIDTH  to RAM write data
- ram_dout  in  DATA_WIDTH  from RAM registered read data

## Operation
- Handshake: a request transfers in a cycle where valid && ready. At most one of a_ready and b_ready is high in any cycle. Requesters hold valid, we, addr and wdata stable until accepted.
- Grant (combinational from valid and prio):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by the prio register is granted.
  - Neither valid: no grant.
- prio register:
  - Reset value selects A.
  - After each accepted request, prio points to the requester that was not granted.
  - Without an acceptance, prio holds its value.
- RAM drive:
  - While a requester is granted, ram_addr and ram_din come from that requester, and ram_we = its we.
  - With no grant, ram_we = 0. ram_addr and ram_din hold their last driven values, so there are no glitches into the RAM.
- Read return:
  - An accepted read sets a registered pending flag and owner for one cycle.
  - In the following cycle, owner's rvalid = 1 and its rdata = ram_dout.
  - The other requester's rdata is zero.
- Writes produce no response.
- The response path has no backpressure. Requesters must accept rvalid the cycle it is asserted.

## Timing
- Reset (rst high at an edge):
  - a_ready, b_ready, a_rvalid, b_rvalid, ram_we are 0.
  - a_rdata, b_rdata, ram_addr, ram_din are 0.
  - prio = A; pending cleared.
- While rst is high, no request is accepted: both ready outputs are held 0.
- Reset mid-operation: a read accepted in the cycle before rst asserts produces no rvalid.
- Read latency: a read accepted at edge N gives rvalid plus data in the cycle after edge N+1 samples ram_dout, i.e. exactly one cycle after acceptance.
  - Returned data is the RAM contents before any write accepted in the same cycle (old-data read).
- Throughput: one accepted request per cycle. Back-to-back reads give rvalid on consecutive cycles, possibly alternating owners.
- Simultaneous read return and new acceptance is legal and independent.
- Write then read of the same address on consecutive cycles returns the newly written data.
- Fairness: with both requesters continuously valid, grants alternate A, B, A, B… starting from the current prio.

## Structure
- Shared package ram_arb_pkg holds:
  - owner_t enum: OWN_A, OWN_B.
  - Default DATA_WIDTH and ADDR_WIDTH constants.
- One sub-module, rr_arbiter2:
  - Inputs: req[1:0], accept, clk, rst.
  - Outputs: one-hot gnt[1:0].
  - Owns the prio register.
- Datapath muxing, the pending/owner pipeline register and the RAM drive stay in ram_port_arbiter.
- Bench instantiates ram_port_arbiter with the single-port RAM as the downstream model.

## Test plan
- Reset: assert rst 2 cycles with a_valid = b_valid = 1 → both ready = 0, both rvalid = 0, ram_we = 0. After release, first grant goes to A.
- Single requester: A writes 0x5A to addr 3, then reads addr 3 → a_ready high both cycles, a_rvalid one cycle after the read with a_rdata = 0x5A, b_rvalid stays 0.
- Contention: A and B both continuously issue reads (A to addr 1 holding 0x11, B to addr 2 holding 0x22) for 6 cycles → grants strictly alternate A, B, A, B, A, B. rvalid alternates one cycle later with correct data.
- Same-cycle old data: B writes 0x77 to addr 5 (holding 0x33) while A's read of addr 5 was accepted in the preceding cycle → A gets 0x33. A's next read of addr 5 returns 0x77.
- Reset mid-read: A's read of addr 7 is accepted, then rst is asserted the next cycle → a_rvalid never pulses, prio returns to A.
- Idle hold: no valid for 3 cycles after a write → ram_we = 0 and ram_addr unchanged throughout.
